mips_cpu_bus_bridge: RTL and testbench

MIPS_CPU_BUS_BRIDGE -- requirements
Module: mips_cpu_bus_bridge

---
 rtl/mips_cpu_bus_pkg.sv | 27 ++
 rtl/mips_cpu_bus_bridge.sv | 189 ++++++++++++++++++
 tb/tb_mips_cpu_bus_bridge.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_bus_pkg.sv
// ---------------------------------------------------------------------------
// mips_cpu_bus_pkg
// Shared types and constants for the MIPS CPU to memory-bus bridge.
//   bus_state_e     : bridge sequencer states (fetch, data access, commit,
//                     timeout error).
//   BYTEENABLE_WORD : byte-enable pattern for a full 32-bit word access.
//   BUS_IDLE_WORD   : value driven on address/writedata when no request.
//   has_data_access : true when the current instruction touches data memory.
// ---------------------------------------------------------------------------
package mips_cpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DATA   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_ERROR  = 2'd3
  } bus_state_e;

  localparam logic [3:0]  BYTEENABLE_WORD = 4'hF;
  localparam logic [3:0]  BYTEENABLE_NONE = 4'h0;
  localparam logic [31:0] BUS_IDLE_WORD   = 32'h0000_0000;

  function automatic logic has_data_access(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/mips_cpu_bus_bridge.sv
// ---------------------------------------------------------------------------
// mips_cpu_bus_bridge
// Sequences a multi-cycle MIPS CPU onto a single shared memory bus: each
// instruction is fetched, then (optionally) one data load/store is made,
// then the CPU is allowed to advance for exactly one cycle.
//
// Parameters
//   TIMEOUT_CYCLES : consecutive waitrequest cycles tolerated before abort
//                    (only meaningful when MIPS_CPU_BUS_BRIDGE_TIMEOUT_EN
//                    is defined).
// Ports
//   clk, reset                : clock, synchronous active-high reset
//   instr_address / _readdata : CPU fetch address / captured instruction
//   data_address, data_read, data_write, data_writedata / data_readdata :
//                               CPU data request / captured load data
//   cpu_clk_enable            : one-cycle strobe letting the CPU advance
//   address, read, write, byteenable, writedata, readdata, waitrequest :
//                               shared memory bus master side
//   bus_error                 : sticky timeout flag (0 unless the timeout
//                               feature is built in)
//
// Build option
//   `define MIPS_CPU_BUS_BRIDGE_TIMEOUT_EN adds the waitrequest watchdog and
//   the reachable ERROR state. Without it the bridge waits indefinitely.
//
// Bus outputs are decoded from the registered state and the (frozen) CPU
// request inputs, so the fetch address tracks the CPU directly once it has
// advanced. They are forced to their idle values whenever reset is high so
// a mid-transaction reset drops the request immediately.
// ---------------------------------------------------------------------------
module mips_cpu_bus_bridge
  import mips_cpu_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  // CPU instruction side
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  // CPU data side
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  // CPU advance strobe
  output logic        cpu_clk_enable,
  // Shared memory bus
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  // Status
  output logic        bus_error
);

  bus_state_e  state_q, state_d;
  logic [31:0] instr_readdata_q, instr_readdata_d;
  logic [31:0] data_readdata_q, data_readdata_d;
  logic        timeout_hit_s;

  assign instr_readdata = instr_readdata_q;
  assign data_readdata  = data_readdata_q;

`ifdef MIPS_CPU_BUS_BRIDGE_TIMEOUT_EN
  localparam int unsigned    CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             bus_busy_s;

  // Watchdog: count consecutive stalled bus cycles, flag the last allowed one.
  always_comb begin
    bus_busy_s    = 1'b0;
    timeout_hit_s = 1'b0;
    wait_cnt_d    = '0;
    if (state_q == ST_FETCH) begin
      bus_busy_s = 1'b1;
    end else if (state_q == ST_DATA) begin
      bus_busy_s = has_data_access(data_read, data_write);
    end else begin
      bus_busy_s = 1'b0;
    end
    // Any completed or idle cycle restarts the count from zero.
    if (bus_busy_s && waitrequest) begin
      timeout_hit_s = (wait_cnt_q == CNT_LAST);
      wait_cnt_d    = timeout_hit_s ? '0 : wait_cnt_q + CNT_W'(1);
    end else begin
      timeout_hit_s = 1'b0;
      wait_cnt_d    = '0;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // ERROR is only left through reset, so the flag is sticky by construction.
  assign bus_error = (state_q == ST_ERROR);
`else
  assign timeout_hit_s = 1'b0;
  assign bus_error     = 1'b0;
`endif

  // Sequencer next-state, capture registers and bus/CPU output decode.
  always_comb begin
    state_d          = state_q;
    instr_readdata_d = instr_readdata_q;
    data_readdata_d  = data_readdata_q;
    address          = BUS_IDLE_WORD;
    writedata        = BUS_IDLE_WORD;
    byteenable       = BYTEENABLE_NONE;
    read             = 1'b0;
    write            = 1'b0;
    cpu_clk_enable   = 1'b0;

    if (reset) begin
      // Registers are reset by the flops; outputs simply stay idle.
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          read       = 1'b1;
          address    = instr_address;
          byteenable = BYTEENABLE_WORD;
          if (!waitrequest) begin
            instr_readdata_d = readdata;
            state_d = has_data_access(data_read, data_write) ? ST_DATA : ST_COMMIT;
          end else begin
            state_d = timeout_hit_s ? ST_ERROR : ST_FETCH;
          end
        end

        ST_DATA: begin
          address    = data_address;
          byteenable = BYTEENABLE_WORD;
          writedata  = data_writedata;
          write      = data_write;
          // A simultaneous read and write request performs the write only.
          read       = data_read & ~data_write;
          if (!has_data_access(data_read, data_write)) begin
            state_d = ST_COMMIT;
          end else if (!waitrequest) begin
            data_readdata_d = data_write ? BUS_IDLE_WORD : readdata;
            state_d         = ST_COMMIT;
          end else begin
            state_d = timeout_hit_s ? ST_ERROR : ST_DATA;
          end
        end

        ST_COMMIT: begin
          cpu_clk_enable = 1'b1;
          state_d        = ST_FETCH;
        end

        ST_ERROR: begin
          state_d = ST_ERROR;
        end

        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  // Sequencer state and captured read data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_FETCH;
      instr_readdata_q <= 32'h0000_0000;
      data_readdata_q  <= 32'h0000_0000;
    end else begin
      state_q          <= state_d;
      instr_readdata_q <= instr_readdata_d;
      data_readdata_q  <= data_readdata_d;
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_mips_cpu_bus_bridge
// Directed and randomized instruction sequences against an instruction-level
// reference: each instruction is a fetch of (1 + fetch waits) cycles, an
// optional data access of (1 + data waits) cycles and a single commit cycle.
// The bench plays both the frozen CPU and the memory slave.
// ---------------------------------------------------------------------------
module tb_mips_cpu_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        cpu_clk_enable;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        bus_error;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;

  // Reference: value the CPU should see on data_readdata.
  logic [31:0] exp_dread;

  always #5 clk = ~clk;

  mips_cpu_bus_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .data_address   (data_address),
    .data_read      (data_read),
    .data_write     (data_write),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata),
    .cpu_clk_enable (cpu_clk_enable),
    .address        (address),
    .read           (read),
    .write          (write),
    .byteenable     (byteenable),
    .writedata      (writedata),
    .readdata       (readdata),
    .waitrequest    (waitrequest),
    .bus_error      (bus_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_read"},      32'(read),           32'd0);
    check({tag, "_write"},     32'(write),          32'd0);
    check({tag, "_address"},   address,             32'd0);
    check({tag, "_writedata"}, writedata,           32'd0);
    check({tag, "_be"},        32'(byteenable),     32'd0);
    check({tag, "_instr"},     instr_readdata,      32'd0);
    check({tag, "_dread"},     data_readdata,       32'd0);
    check({tag, "_cce"},       32'(cpu_clk_enable), 32'd0);
    check({tag, "_buserr"},    32'(bus_error),      32'd0);
  endtask

  // One full instruction; entered and left #1 after a rising edge in FETCH.
  task automatic run_instr(input logic [31:0] ia, input logic [31:0] da,
                           input logic rd, input logic wr, input logic [31:0] wd,
                           input int wf, input int wdw,
                           input logic [31:0] idata, input logic [31:0] ddata);
    logic acc;
    acc            = rd | wr;
    instr_address  = ia;
    data_address   = da;
    data_read      = rd;
    data_write     = wr;
    data_writedata = wd;
    for (int k = 0; k <= wf; k++) begin
      waitrequest = (k < wf);
      readdata    = (k < wf) ? $urandom() : idata;
      @(negedge clk);
      check("fetch_read",  32'(read),           32'd1);
      check("fetch_write", 32'(write),          32'd0);
      check("fetch_addr",  address,             ia);
      check("fetch_be",    32'(byteenable),     32'h0000_000F);
      check("fetch_cce",   32'(cpu_clk_enable), 32'd0);
      @(posedge clk); #1;
    end
    if (acc) begin
      for (int k = 0; k <= wdw; k++) begin
        waitrequest = (k < wdw);
        readdata    = (k < wdw) ? $urandom() : ddata;
        @(negedge clk);
        check("data_read",   32'(read),           32'(rd & ~wr));
        check("data_write",  32'(write),          32'(wr));
        check("data_addr",   address,             da);
        check("data_wdata",  writedata,           wd);
        check("data_be",     32'(byteenable),     32'h0000_000F);
        check("data_cce",    32'(cpu_clk_enable), 32'd0);
        check("data_instr",  instr_readdata,      idata);
        @(posedge clk); #1;
      end
      exp_dread = wr ? 32'h0000_0000 : ddata;
    end
    waitrequest = 1'($urandom_range(0, 1));
    readdata    = $urandom();
    @(negedge clk);
    check("commit_cce",    32'(cpu_clk_enable), 32'd1);
    check("commit_read",   32'(read),           32'd0);
    check("commit_write",  32'(write),          32'd0);
    check("commit_instr",  instr_readdata,      idata);
    check("commit_dread",  data_readdata,       exp_dread);
    check("commit_buserr", 32'(bus_error),      32'd0);
    @(posedge clk); #1;
  endtask

  // Watchdog so a broken design can never hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d checks", n_total);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    reset          = 1'b1;
    instr_address  = 32'hBFC0_0000;
    data_address   = 32'h0000_1000;
    data_read      = 1'b1;
    data_write     = 1'b1;
    data_writedata = 32'hFFFF_FFFF;
    readdata       = 32'h1234_5678;
    waitrequest    = 1'b0;
    exp_dread      = 32'h0000_0000;
    @(posedge clk);
    @(posedge clk); #1;
    check_reset_outputs("por");
    reset = 1'b0;

    // Zero-wait fetch, no data access: 2-cycle instruction.
    run_instr(32'hBFC0_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0, 0, 0, 32'h2402_0005, 32'h0);
    // Load with three data wait states: commit in cycle 6.
    run_instr(32'hBFC0_0004, 32'h0000_1000, 1'b1, 1'b0, 32'h0, 0, 3, 32'h8C03_1000, 32'hDEAD_BEEF);
    // Store: data_readdata returns to zero.
    run_instr(32'hBFC0_0008, 32'h0000_1000, 1'b0, 1'b1, 32'h0000_00AB, 0, 0, 32'hAC03_1000, 32'h5555_5555);
    // Read and write together: write only.
    run_instr(32'hBFC0_000C, 32'h0000_2000, 1'b1, 1'b1, 32'h0000_55AA, 1, 1, 32'hAC04_2000, 32'h7777_7777);
    // Load a non-zero value so the reset check below is meaningful.
    run_instr(32'hBFC0_0010, 32'h0000_3000, 1'b1, 1'b0, 32'h0, 2, 2, 32'h8C05_3000, 32'h1234_5678);

    // Reset asserted during the second waitrequest cycle of a fetch.
    instr_address = 32'hBFC0_0100;
    data_read     = 1'b0;
    data_write    = 1'b0;
    waitrequest   = 1'b1;
    readdata      = $urandom();
    @(negedge clk);
    check("rst_pre_read", 32'(read), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    reset     = 1'b0;
    exp_dread = 32'h0000_0000;
    run_instr(32'hBFC0_0000, 32'h0, 1'b0, 1'b0, 32'h0, 0, 0, 32'h0000_0001, 32'h0);

    // Randomized instruction stream.
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  op;
      logic [31:0] ia;
      logic [31:0] da;
      op = 2'($urandom_range(0, 3));
      ia = $urandom() & 32'hFFFF_FFFC;
      da = $urandom() & 32'hFFFF_FFFC;
      run_instr(ia, da, op[0], op[1], $urandom(),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                $urandom(), $urandom());
    end

`ifdef MIPS_CPU_BUS_BRIDGE_TIMEOUT_EN
    // Fetch stalled forever: abort after four waitrequest cycles.
    instr_address = 32'hBFC0_0200;
    data_read     = 1'b0;
    data_write    = 1'b0;
    waitrequest   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("to_read",   32'(read),      32'd1);
      check("to_buserr", 32'(bus_error), 32'd0);
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) begin
      waitrequest = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("err_read",   32'(read),           32'd0);
      check("err_write",  32'(write),          32'd0);
      check("err_buserr", 32'(bus_error),      32'd1);
      check("err_cce",    32'(cpu_clk_enable), 32'd0);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check("err_clear", 32'(bus_error), 32'd0);
    reset     = 1'b0;
    exp_dread = 32'h0000_0000;
    run_instr(32'hBFC0_0000, 32'h0, 1'b0, 1'b0, 32'h0, 0, 0, 32'h0000_0002, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
